// File: rtl/systolic_feeder_if.sv
// Tile input handshake and skewed array-edge outputs of the systolic feeder.
interface systolic_feeder_if #(
  parameter int unsigned ARRAY_SIZE = 8,
  parameter int unsigned DATA_WIDTH = 4
);
  localparam int unsigned VW = ARRAY_SIZE * DATA_WIDTH;

  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] in_act;
  logic [VW-1:0] in_weight;
  logic          load;
  logic [VW-1:0] activations;
  logic [VW-1:0] weights;
  logic          busy;
  logic          done;

  modport slave (
    input  in_valid, in_act, in_weight,
    output in_ready, load, activations, weights, busy, done
  );

  modport master (
    output in_valid, in_act, in_weight,
    input  in_ready, load, activations, weights, busy, done
  );
endinterface

// File: rtl/systolic_feeder.sv
// Buffers one tile of activation/weight vectors, then replays it to the MAC array
// with lane i delayed by i cycles, followed by a zero flush and a done pulse.
module systolic_feeder #(
  parameter int unsigned ARRAY_SIZE   = 8,
  parameter int unsigned DATA_WIDTH   = 4,
  parameter int unsigned FLUSH_CYCLES = ARRAY_SIZE
) (
  input  logic              clk,
  input  logic              reset,
  systolic_feeder_if.slave  bus
);
  localparam int unsigned VW    = ARRAY_SIZE * DATA_WIDTH;
  localparam int unsigned STEPS = 2 * ARRAY_SIZE - 1;
  localparam int unsigned KW    = $clog2(ARRAY_SIZE) + 1;
  localparam int unsigned TW    = $clog2(STEPS) + 1;
  localparam int unsigned FW    = $clog2((FLUSH_CYCLES > 0) ? FLUSH_CYCLES : 1) + 1;
  localparam int unsigned AW    = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
  localparam int unsigned FLAST = (FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0;

  typedef enum logic [1:0] {S_FILL, S_STREAM, S_FLUSH, S_DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [KW-1:0] r_k, w_k_nxt;
  logic [TW-1:0] r_t, w_t_nxt;
  logic [FW-1:0] r_f, w_f_nxt;

  logic [VW-1:0] r_act_buf [ARRAY_SIZE];
  logic [VW-1:0] r_wt_buf  [ARRAY_SIZE];

  logic          r_in_ready, r_load, r_busy, r_done;
  logic [VW-1:0] r_act, r_wt;
  logic          w_in_ready, w_load, w_busy, w_done;
  logic [VW-1:0] w_act, w_wt;
  logic          w_accept;
  int            w_idx;

  assign w_accept = (r_state == S_FILL) && bus.in_valid;

  // Next state, counters, and the registered output image of the next cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_t_nxt     = r_t;
    w_f_nxt     = r_f;
    w_act       = '0;
    w_wt        = '0;
    w_idx       = 0;

    case (r_state)
      S_FILL: begin
        if (w_accept) begin
          if (r_k == KW'(ARRAY_SIZE - 1)) begin
            w_state_nxt = S_STREAM;
            w_k_nxt     = '0;
            w_t_nxt     = '0;
          end else begin
            w_k_nxt = r_k + KW'(1);
          end
        end
      end
      S_STREAM: begin
        if (r_t == TW'(STEPS - 1)) begin
          w_t_nxt     = '0;
          w_f_nxt     = '0;
          w_state_nxt = (FLUSH_CYCLES == 0) ? S_DONE : S_FLUSH;
        end else begin
          w_t_nxt = r_t + TW'(1);
        end
      end
      S_FLUSH: begin
        if (r_f == FW'(FLAST)) begin
          w_f_nxt     = '0;
          w_state_nxt = S_DONE;
        end else begin
          w_f_nxt = r_f + FW'(1);
        end
      end
      S_DONE:  w_state_nxt = S_FILL;
      default: w_state_nxt = S_FILL;
    endcase

    w_in_ready = (w_state_nxt == S_FILL);
    w_load     = (w_state_nxt == S_STREAM) || (w_state_nxt == S_FLUSH);
    w_busy     = (w_state_nxt != S_FILL);
    w_done     = (w_state_nxt == S_DONE);

    // Diagonal skew; the vector being accepted this edge is bypassed in case step 0 needs it.
    if (w_state_nxt == S_STREAM) begin
      for (int i = 0; i < int'(ARRAY_SIZE); i++) begin
        w_idx = int'(w_t_nxt) - i;
        if (w_idx >= 0 && w_idx < int'(ARRAY_SIZE)) begin
          if (w_accept && int'(r_k) == w_idx) begin
            w_act[i*DATA_WIDTH +: DATA_WIDTH] = bus.in_act[i*DATA_WIDTH +: DATA_WIDTH];
            w_wt[i*DATA_WIDTH +: DATA_WIDTH]  = bus.in_weight[i*DATA_WIDTH +: DATA_WIDTH];
          end else begin
            w_act[i*DATA_WIDTH +: DATA_WIDTH] = r_act_buf[AW'(w_idx)][i*DATA_WIDTH +: DATA_WIDTH];
            w_wt[i*DATA_WIDTH +: DATA_WIDTH]  = r_wt_buf[AW'(w_idx)][i*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_FILL;
      r_k        <= '0;
      r_t        <= '0;
      r_f        <= '0;
      r_in_ready <= 1'b1;
      r_load     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_act      <= '0;
      r_wt       <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_k        <= w_k_nxt;
      r_t        <= w_t_nxt;
      r_f        <= w_f_nxt;
      r_in_ready <= w_in_ready;
      r_load     <= w_load;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_act      <= w_act;
      r_wt       <= w_wt;
    end
  end

  // Tile storage; contents are only observable once a full tile has been accepted.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_act_buf[r_k[AW-1:0]] <= bus.in_act;
      r_wt_buf[r_k[AW-1:0]]  <= bus.in_weight;
    end
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.load        = r_load;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.activations = r_act;
  assign bus.weights     = r_wt;
endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder: scoreboard of skewed stream samples,
// table of reference steps, and hand-written reset / back-to-back / no-flush sequences.
module tb_systolic_feeder;
  localparam int unsigned N  = 4;
  localparam int unsigned DW = 4;
  localparam int unsigned F  = 4;
  localparam int unsigned VW = N * DW;
  localparam int unsigned SL = 2 * N - 1;

  typedef struct packed {
    logic [VW-1:0] act;
    logic [VW-1:0] wt;
  } samp_t;

  typedef struct {
    int            step;
    logic [VW-1:0] act;
    logic [VW-1:0] wt;
  } spot_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  systolic_feeder_if #(.ARRAY_SIZE(N), .DATA_WIDTH(DW)) bus ();
  systolic_feeder_if #(.ARRAY_SIZE(N), .DATA_WIDTH(DW)) bus0 ();

  systolic_feeder #(.ARRAY_SIZE(N), .DATA_WIDTH(DW), .FLUSH_CYCLES(F)) dut (
    .clk(clk), .reset(rst_n), .bus(bus));
  systolic_feeder #(.ARRAY_SIZE(N), .DATA_WIDTH(DW), .FLUSH_CYCLES(0)) dut0 (
    .clk(clk), .reset(rst_n), .bus(bus0));

  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  int    last_acc = 0;
  int    first_acc = -1;
  int    load_cnt = 0, done_cnt = 0;
  int    ld0 = 0, d0 = 0, d0_cyc = 0;
  bit    cap_en = 1'b0;
  int    cap_n = 0;
  samp_t cap [16];
  samp_t cap0 [16];
  samp_t exp_q [$];
  spot_t spots [8];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Reference skew model: expected samples for every load cycle of one tile.
  task automatic push_tile(input logic [VW-1:0] va [N], input logic [VW-1:0] vw [N]);
    samp_t s;
    int    idx;
    for (int t = 0; t < int'(SL); t++) begin
      s = '0;
      for (int i = 0; i < int'(N); i++) begin
        idx = t - i;
        if (idx >= 0 && idx < int'(N)) begin
          s.act[i*DW +: DW] = va[idx][i*DW +: DW];
          s.wt[i*DW +: DW]  = vw[idx][i*DW +: DW];
        end
      end
      exp_q.push_back(s);
    end
    for (int j = 0; j < int'(F); j++) exp_q.push_back('0);
  endtask

  task automatic send_vec(input logic [VW-1:0] a, input logic [VW-1:0] w);
    int guard = 0;
    bus.in_valid  = 1'b1;
    bus.in_act    = a;
    bus.in_weight = w;
    while (!bus.in_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("send_wait_bound", 64'(guard < 200), 64'd1);
    @(posedge clk); #1;
    last_acc = cyc;
    if (first_acc < 0) first_acc = cyc;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_tile(input int base, input bit toggle, input bit rnd);
    logic [VW-1:0] va [N];
    logic [VW-1:0] vw [N];
    for (int k = 0; k < int'(N); k++) begin
      for (int i = 0; i < int'(N); i++) begin
        va[k][i*DW +: DW] = rnd ? DW'($urandom_range(0, 15)) : DW'(base + k);
        vw[k][i*DW +: DW] = rnd ? DW'($urandom_range(0, 15)) : DW'(-(base + k));
      end
    end
    push_tile(va, vw);
    for (int k = 0; k < int'(N); k++) begin
      send_vec(va[k], vw[k]);
      if (toggle) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic wait_ready(output int rc);
    int guard = 0;
    do begin
      @(posedge clk); #1;
      guard++;
    end while (!bus.in_ready && guard < 100);
    chk("ready_wait_bound", 64'(guard < 100), 64'd1);
    rc = cyc;
  endtask

  // Scoreboard monitor for the FLUSH_CYCLES=F instance.
  always @(negedge clk) begin
    samp_t s;
    if (bus.load) begin
      load_cnt++;
      chk("stream_queue_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        s = exp_q.pop_front();
        chk("stream_act", 64'(bus.activations), 64'(s.act));
        chk("stream_wt", 64'(bus.weights), 64'(s.wt));
      end
      if (cap_en && cap_n < 16) begin
        cap[cap_n] = '{act: bus.activations, wt: bus.weights};
        cap_n++;
      end
    end
    if (bus.done) begin
      done_cnt++;
      chk("done_load", 64'(bus.load), 64'd0);
      chk("done_busy", 64'(bus.busy), 64'd1);
      chk("done_lanes", 64'(bus.activations | bus.weights), 64'd0);
    end
  end

  // Recorder for the FLUSH_CYCLES=0 instance.
  always @(negedge clk) begin
    if (bus0.load) begin
      if (ld0 < 16) cap0[ld0] = '{act: bus0.activations, wt: bus0.weights};
      ld0++;
    end
    if (bus0.done) begin
      d0++;
      d0_cyc = cyc;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int rc, e0, e0a;

    spots[0] = '{0, 16'h0001, 16'h000F};
    spots[1] = '{1, 16'h0012, 16'h00FE};
    spots[2] = '{2, 16'h0123, 16'h0FED};
    spots[3] = '{3, 16'h1234, 16'hFEDC};
    spots[4] = '{4, 16'h2340, 16'hEDC0};
    spots[5] = '{5, 16'h3400, 16'hDC00};
    spots[6] = '{6, 16'h4000, 16'hC000};
    spots[7] = '{7, 16'h0000, 16'h0000};

    bus.in_valid  = 1'b0; bus.in_act  = '0; bus.in_weight  = '0;
    bus0.in_valid = 1'b0; bus0.in_act = '0; bus0.in_weight = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
    chk("reset_load", 64'(bus.load), 64'd0);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    chk("reset_act", 64'(bus.activations), 64'd0);
    chk("reset_wt", 64'(bus.weights), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Reference tile: values k+1 / -(k+1), captured for the step table.
    cap_en = 1'b1; cap_n = 0; load_cnt = 0; done_cnt = 0;
    send_tile(1, 1'b0, 1'b0);
    e0 = last_acc;
    wait_ready(rc);
    cap_en = 1'b0;
    chk("ready_after_e0", 64'(rc - e0), 64'd12);
    chk("load_cycles", 64'(load_cnt), 64'd11);
    chk("done_pulses", 64'(done_cnt), 64'd1);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    for (int s = 0; s < 8; s++) begin
      chk($sformatf("spot_act_step%0d", spots[s].step), 64'(cap[spots[s].step].act), 64'(spots[s].act));
      chk($sformatf("spot_wt_step%0d", spots[s].step), 64'(cap[spots[s].step].wt), 64'(spots[s].wt));
    end

    // Toggling in_valid during fill, then in_valid held high with junk through the stream.
    load_cnt = 0; done_cnt = 0;
    send_tile(1, 1'b1, 1'b0);
    bus.in_valid = 1'b1; bus.in_act = 16'hA5A5; bus.in_weight = 16'h5A5A;
    for (int g = 0; g < 40 && !bus.done; g++) begin
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    wait_ready(rc);
    chk("toggle_load_cycles", 64'(load_cnt), 64'd11);
    chk("toggle_queue_drained", 64'(exp_q.size()), 64'd0);

    // Partial fill discarded by reset.
    send_vec(16'h7777, 16'h7777);
    send_vec(16'h6666, 16'h6666);
    rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset asserted while step 2 is on the lanes.
    send_tile(1, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_reset_step2_act", 64'(bus.activations), 64'h0123);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("abort_in_ready", 64'(bus.in_ready), 64'd1);
    chk("abort_load", 64'(bus.load), 64'd0);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_lanes", 64'({bus.activations, bus.weights}), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    load_cnt = 0; done_cnt = 0;
    send_tile(0, 1'b0, 1'b1);
    wait_ready(rc);
    chk("post_reset_load_cycles", 64'(load_cnt), 64'd11);
    chk("post_reset_queue_drained", 64'(exp_q.size()), 64'd0);

    // Back-to-back tiles; the second accept lands on the first FILL cycle after DONE.
    load_cnt = 0; done_cnt = 0;
    send_tile(1, 1'b0, 1'b0);
    e0a = last_acc;
    first_acc = -1;
    send_tile(5, 1'b0, 1'b0);
    chk("b2b_first_accept_gap", 64'(first_acc - e0a), 64'(2 * N + F + 1));
    wait_ready(rc);
    chk("b2b_load_cycles", 64'(load_cnt), 64'd22);
    chk("b2b_done_pulses", 64'(done_cnt), 64'd2);
    chk("b2b_queue_drained", 64'(exp_q.size()), 64'd0);

    // FLUSH_CYCLES=0 instance: DONE right after step 6.
    ld0 = 0; d0 = 0;
    for (int k = 0; k < int'(N); k++) begin
      chk("nf_ready", 64'(bus0.in_ready), 64'd1);
      bus0.in_valid = 1'b1;
      for (int i = 0; i < int'(N); i++) begin
        bus0.in_act[i*DW +: DW]    = DW'(k + 1);
        bus0.in_weight[i*DW +: DW] = DW'(-(k + 1));
      end
      @(posedge clk); #1;
    end
    bus0.in_valid = 1'b0;
    e0 = cyc;
    repeat (12) @(posedge clk);
    #1;
    chk("nf_load_cycles", 64'(ld0), 64'd7);
    chk("nf_done_pulses", 64'(d0), 64'd1);
    chk("nf_done_offset", 64'(d0_cyc - e0), 64'd7);
    chk("nf_step0_wt", 64'(cap0[0].wt), 64'h000F);
    chk("nf_step6_act", 64'(cap0[6].act), 64'h4000);
    chk("nf_in_ready_back", 64'(bus0.in_ready), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
